goofy_alu_driver: RTL and testbench

Command-side initiator for the GoofyALU. It accepts one ALU command at a time over a valid/ready handshake. For each command it loads the ALU operand registers, pulses the required operation strobe for the correct number of cycles, and captures `alu_out` and the flags. It then returns them over a valid/ready response channel. It sits between the control unit/decoder and the ALU, and is the only block that drives ALU write and strobe inputs.

---
 rtl/goofy_alu_pkg.sv | 37 +++
 rtl/goofy_alu_driver_if.sv | 56 +++++
 rtl/goofy_alu_op_decode.sv | 23 ++
 rtl/goofy_alu_driver.sv | 165 ++++++++++++++++
 tb/tb_goofy_alu_driver.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/goofy_alu_pkg.sv
// Shared GoofyALU definitions: op codes, driver state encoding, strobe vector and op classes.
// Strobe vector bit positions equal the op codes, so a decoded op indexes its strobe directly.
package goofy_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_CMP  = 4'd7;
  localparam logic [3:0] OP_HLT  = 4'd8;
  localparam logic [3:0] OP_FRES = 4'd9;

  localparam int NUM_STB       = 10;
  localparam int ARITH_CYC_DEF = 2;

  typedef logic [NUM_STB-1:0] stb_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_CAPT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    CLS_ARITH,
    CLS_LOGIC,
    CLS_NOLOAD,
    CLS_ILLEGAL
  } op_cls_e;

endpackage

// File: rtl/goofy_alu_driver_if.sv
// Command/response channel plus the ALU operand, strobe and result wires of the GoofyALU driver.
// slave = the driver's view; master = control unit and ALU side.
interface goofy_alu_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_ov;
  logic       rsp_eq;
  logic       rsp_hlt;
  logic       rsp_err;

  logic       alu0w;
  logic       alu1w;
  logic [7:0] alu0d;
  logic [7:0] alu1d;

  logic       alu_add;
  logic       alu_add_ov;
  logic       alu_sub;
  logic       alu_sub_ov;
  logic       alu_and;
  logic       alu_or;
  logic       alu_not;
  logic       alu_cmp;
  logic       alu_hlt;
  logic       alu_flag_res;

  logic [7:0] alu_out;
  logic       alu_flag_ov_o;
  logic       alu_flag_eq_o;
  logic       alu_flag_hlt_o;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  alu_out, alu_flag_ov_o, alu_flag_eq_o, alu_flag_hlt_o,
    output cmd_ready, rsp_valid, rsp_data, rsp_ov, rsp_eq, rsp_hlt, rsp_err,
    output alu0w, alu1w, alu0d, alu1d,
    output alu_add, alu_add_ov, alu_sub, alu_sub_ov, alu_and, alu_or,
    output alu_not, alu_cmp, alu_hlt, alu_flag_res
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output alu_out, alu_flag_ov_o, alu_flag_eq_o, alu_flag_hlt_o,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ov, rsp_eq, rsp_hlt, rsp_err,
    input  alu0w, alu1w, alu0d, alu1d,
    input  alu_add, alu_add_ov, alu_sub, alu_sub_ov, alu_and, alu_or,
    input  alu_not, alu_cmp, alu_hlt, alu_flag_res
  );
endinterface

// File: rtl/goofy_alu_op_decode.sv
// Combinational op decode: one-hot strobe vector and op class; zero strobes for illegal codes.
// Shared with the instruction decoder, so it carries no state.
module goofy_alu_op_decode
  import goofy_alu_pkg::*;
(
  input  logic [3:0] i_op,
  output stb_t       o_stb,
  output op_cls_e    o_cls
);

  always_comb begin
    o_stb = '0;
    o_cls = CLS_ILLEGAL;
    case (i_op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: o_cls = CLS_ARITH;
      OP_AND, OP_OR, OP_NOT, OP_CMP:    o_cls = CLS_LOGIC;
      OP_HLT, OP_FRES:                  o_cls = CLS_NOLOAD;
      default:                          o_cls = CLS_ILLEGAL;
    endcase
    if (o_cls != CLS_ILLEGAL) o_stb[i_op] = 1'b1;
  end

endmodule

// File: rtl/goofy_alu_driver.sv
// GoofyALU command initiator: load operands, strobe the op, capture result, answer over rsp channel.
// Response 1..4 edges after accept depending on op class; one command in flight, rsp held until rsp_ready.
module goofy_alu_driver
  import goofy_alu_pkg::*;
#(
  parameter int ARITH_CYC = ARITH_CYC_DEF,
  parameter bit INIT_FRES = 1'b1
) (
  input  logic               clk,
  input  logic               res,
  goofy_alu_driver_if.slave  bus
);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] r_op;
  logic [3:0] w_op_sel;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_len;
  logic       r_init_done;
  logic       r_err;
  logic       w_acc;
  logic       w_reject;
  stb_t       w_dec_stb;
  op_cls_e    w_cls;

  logic       w_cmd_ready_nx;
  logic       w_rsp_valid_nx;
  logic       w_wr_nx;
  logic [7:0] w_alu0d_nx;
  logic [7:0] w_alu1d_nx;
  stb_t       w_stb_nx;

  logic       r_cmd_ready;
  logic       r_rsp_valid;
  logic       r_wr;
  logic [7:0] r_alu0d;
  logic [7:0] r_alu1d;
  stb_t       r_stb;
  logic [7:0] r_rsp_data;
  logic       r_rsp_ov;
  logic       r_rsp_eq;
  logic       r_rsp_hlt;
  logic       r_rsp_err;

  assign w_acc     = (r_state == ST_IDLE) && r_cmd_ready && bus.cmd_valid;
  assign w_op_sel  = w_acc ? bus.cmd_op : r_op;
  assign w_reject  = (w_cls == CLS_ILLEGAL) || (bus.alu_flag_hlt_o && (bus.cmd_op != OP_FRES));
  assign w_cnt_len = (w_cls == CLS_ARITH) ? 8'(ARITH_CYC - 1) : 8'd0;

  goofy_alu_op_decode u_dec (
    .i_op  (w_op_sel),
    .o_stb (w_dec_stb),
    .o_cls (w_cls)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      if (INIT_FRES) r_state <= ST_INIT;
      else           r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Rejected commands pass through CAPT so an error answers one edge after acceptance.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT: w_next = r_init_done ? ST_IDLE : ST_INIT;
      ST_IDLE: begin
        if (w_acc) begin
          if (w_reject)                 w_next = ST_CAPT;
          else if (w_cls == CLS_NOLOAD) w_next = ST_EXEC;
          else                          w_next = ST_LOAD;
        end
      end
      ST_LOAD: w_next = ST_EXEC;
      ST_EXEC: w_next = (r_cnt == 8'd0) ? ST_CAPT : ST_EXEC;
      ST_CAPT: w_next = ST_RESP;
      ST_RESP: w_next = bus.rsp_ready ? ST_IDLE : ST_RESP;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready_nx = (w_next == ST_IDLE);
    w_rsp_valid_nx = (w_next == ST_RESP);
    w_wr_nx        = (w_next == ST_LOAD);
    w_alu0d_nx     = (w_next == ST_LOAD) ? bus.cmd_a : 8'd0;
    w_alu1d_nx     = (w_next == ST_LOAD) ? bus.cmd_b : 8'd0;
    w_stb_nx       = (w_next == ST_EXEC) ? w_dec_stb : '0;
    if ((r_state == ST_INIT) && !r_init_done) w_stb_nx[OP_FRES] = 1'b1;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_wr        <= 1'b0;
      r_alu0d     <= 8'd0;
      r_alu1d     <= 8'd0;
      r_stb       <= '0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_wr        <= w_wr_nx;
      r_alu0d     <= w_alu0d_nx;
      r_alu1d     <= w_alu1d_nx;
      r_stb       <= w_stb_nx;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_op        <= 4'd0;
      r_cnt       <= 8'd0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_data  <= 8'd0;
      r_rsp_ov    <= 1'b0;
      r_rsp_eq    <= 1'b0;
      r_rsp_hlt   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (r_state == ST_INIT) r_init_done <= 1'b1;
      if (w_acc) begin
        r_op  <= bus.cmd_op;
        r_err <= w_reject;
      end
      if ((w_next == ST_EXEC) && (r_state != ST_EXEC)) r_cnt <= w_cnt_len;
      else if (r_state == ST_EXEC)                     r_cnt <= r_cnt - 8'd1;
      if (r_state == ST_CAPT) begin
        r_rsp_data <= r_err ? 8'd0 : bus.alu_out;
        r_rsp_ov   <= r_err ? 1'b0 : bus.alu_flag_ov_o;
        r_rsp_eq   <= r_err ? 1'b0 : bus.alu_flag_eq_o;
        r_rsp_hlt  <= r_err ? 1'b0 : bus.alu_flag_hlt_o;
        r_rsp_err  <= r_err;
      end
    end
  end

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_ov       = r_rsp_ov;
  assign bus.rsp_eq       = r_rsp_eq;
  assign bus.rsp_hlt      = r_rsp_hlt;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.alu0w        = r_wr;
  assign bus.alu1w        = r_wr;
  assign bus.alu0d        = r_alu0d;
  assign bus.alu1d        = r_alu1d;
  assign bus.alu_add      = r_stb[OP_ADD];
  assign bus.alu_add_ov   = r_stb[OP_ADDC];
  assign bus.alu_sub      = r_stb[OP_SUB];
  assign bus.alu_sub_ov   = r_stb[OP_SUBC];
  assign bus.alu_and      = r_stb[OP_AND];
  assign bus.alu_or       = r_stb[OP_OR];
  assign bus.alu_not      = r_stb[OP_NOT];
  assign bus.alu_cmp      = r_stb[OP_CMP];
  assign bus.alu_hlt      = r_stb[OP_HLT];
  assign bus.alu_flag_res = r_stb[OP_FRES];

endmodule

// File: tb/tb_goofy_alu_driver.sv
// Bench for goofy_alu_driver with a behavioural negedge GoofyALU (two-stage arithmetic) and a response scoreboard.
module tb_goofy_alu_driver;
  import goofy_alu_pkg::*;

  logic clk = 1'b0;
  logic res = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  goofy_alu_driver_if bus();

  goofy_alu_driver #(.ARITH_CYC(2), .INIT_FRES(1'b1)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  // Behavioural ALU: arithmetic computes on the first strobe negedge and commits on the second.
  logic [7:0] m_r0 = 8'd0, m_r1 = 8'd0, m_out = 8'd0, m_s1 = 8'd0;
  logic       m_ov = 1'b0, m_eq = 1'b0, m_hlt = 1'b0, m_s1ov = 1'b0, m_prev = 1'b0;
  logic       m_arith;

  assign bus.alu_out        = m_out;
  assign bus.alu_flag_ov_o  = m_ov;
  assign bus.alu_flag_eq_o  = m_eq;
  assign bus.alu_flag_hlt_o = m_hlt;

  always @(negedge clk) begin
    m_arith = bus.alu_add | bus.alu_add_ov | bus.alu_sub | bus.alu_sub_ov;
    if (bus.alu0w) m_r0 <= bus.alu0d;
    if (bus.alu1w) m_r1 <= bus.alu1d;
    if (m_arith && !m_prev) begin
      if (bus.alu_add)    {m_s1ov, m_s1} <= {1'b0, m_r0} + {1'b0, m_r1};
      if (bus.alu_add_ov) {m_s1ov, m_s1} <= {1'b0, m_r0} + {1'b0, m_r1} + {8'd0, m_ov};
      if (bus.alu_sub)    {m_s1ov, m_s1} <= {1'b0, m_r0} - {1'b0, m_r1};
      if (bus.alu_sub_ov) {m_s1ov, m_s1} <= {1'b0, m_r0} - {1'b0, m_r1} - {8'd0, m_ov};
    end else if (m_arith) begin
      m_out <= m_s1;
      m_ov  <= m_s1ov;
    end
    m_prev <= m_arith;
    if (bus.alu_and) m_out <= m_r0 & m_r1;
    if (bus.alu_or)  m_out <= m_r0 | m_r1;
    if (bus.alu_not) m_out <= ~m_r0;
    if (bus.alu_cmp) m_eq  <= (m_r0 == m_r1);
    if (bus.alu_hlt) m_hlt <= 1'b1;
    if (bus.alu_flag_res) begin
      m_ov  <= 1'b0;
      m_eq  <= 1'b0;
      m_hlt <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ov, eq, hlt, err;
    int         lat;
    int         acc;
  } exp_t;
  exp_t q[$];

  // Strobe activity totals sampled where the ALU samples.
  logic [9:0] stb_vec;
  int tot_add = 0, tot_wr = 0, tot_stb = 0, tot_fres = 0, onehot_viol = 0;
  assign stb_vec = {bus.alu_add, bus.alu_add_ov, bus.alu_sub, bus.alu_sub_ov, bus.alu_and,
                    bus.alu_or, bus.alu_not, bus.alu_cmp, bus.alu_hlt, bus.alu_flag_res};

  always @(negedge clk) begin
    if (bus.alu_add)      tot_add++;
    if (bus.alu0w)        tot_wr++;
    if (stb_vec != '0)    tot_stb++;
    if (bus.alu_flag_res) tot_fres++;
    if ($countones(stb_vec) > 1) onehot_viol++;
  end

  // Response monitor: compare on the first valid cycle, then demand stability while stalled.
  logic       prev_v = 1'b0;
  logic [11:0] held;
  exp_t       e;
  always @(negedge clk) begin
    if (bus.rsp_valid && !prev_v) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rsp_data",    {24'd0, bus.rsp_data}, {24'd0, e.data});
        chk("rsp_ov",      {31'd0, bus.rsp_ov},   {31'd0, e.ov});
        chk("rsp_eq",      {31'd0, bus.rsp_eq},   {31'd0, e.eq});
        chk("rsp_hlt",     {31'd0, bus.rsp_hlt},  {31'd0, e.hlt});
        chk("rsp_err",     {31'd0, bus.rsp_err},  {31'd0, e.err});
        chk("rsp_latency", cyc - e.acc, e.lat);
      end
      held = {bus.rsp_data, bus.rsp_ov, bus.rsp_eq, bus.rsp_hlt, bus.rsp_err};
    end else if (bus.rsp_valid) begin
      chk("rsp_stable", {20'd0, bus.rsp_data, bus.rsp_ov, bus.rsp_eq, bus.rsp_hlt, bus.rsp_err},
          {20'd0, held});
    end
    prev_v = bus.rsp_valid;
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] d, input logic ov, input logic eq, input logic hlt,
                      input logic err, input int lat, input bit push);
    bit got = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    for (int i = 0; i < 40; i++) begin
      if (bus.cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("cmd_accept", {31'd0, got}, 32'd1);
    if (got) begin
      if (push) q.push_back('{d, ov, eq, hlt, err, lat, cyc + 1});
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'hE;
    bus.cmd_a     = 8'hFF;
    bus.cmd_b     = 8'hFF;
  endtask

  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("rsp_done", {31'd0, done}, 32'd1);
  endtask

  task automatic release_and_init(input string tag);
    int  f0 = tot_fres;
    bit  rdy = 1'b0;
    @(negedge clk);
    res = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        rdy = 1'b1;
        break;
      end
    end
    chk({tag, "_fres_pulses"}, tot_fres - f0, 32'd1);
    chk({tag, "_cmd_ready"}, {31'd0, rdy}, 32'd1);
  endtask

  int s_add, s_wr, s_stb;
  bit seen;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'd0;
    bus.cmd_a     = 8'd0;
    bus.cmd_b     = 8'd0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_strobes",   {20'd0, stb_vec, bus.alu0w, bus.alu1w}, 32'd0);
    chk("rst_rsp_data",  {24'd0, bus.rsp_data}, 32'd0);
    release_and_init("init");

    s_add = tot_add; s_wr = tot_wr;
    send(OP_ADD, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b1);
    wait_done();
    chk("add_strobe_cycles", tot_add - s_add, 32'd2);
    chk("add_wr_cycles",     tot_wr - s_wr,   32'd1);

    send(OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1); wait_done();
    send(OP_NOT, 8'h0F, 8'h00, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1); wait_done();
    send(OP_CMP, 8'd7,  8'd7,  8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1); wait_done();
    send(OP_CMP, 8'd7,  8'd8,  8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1); wait_done();
    send(OP_SUB, 8'd5,  8'd3,  8'd2,  1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1); wait_done();
    send(OP_HLT, 8'd0,  8'd0,  8'd2,  1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1); wait_done();

    s_stb = tot_stb; s_wr = tot_wr;
    send(OP_ADD, 8'd1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    wait_done();
    chk("halted_no_strobes", tot_stb - s_stb, 32'd0);
    chk("halted_no_writes",  tot_wr - s_wr,   32'd0);

    send(OP_FRES, 8'd0, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1); wait_done();
    send(OP_ADD,  8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1); wait_done();

    bus.rsp_ready = 1'b0;
    send(4'd12, 8'd9, 8'd9, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    wait_done();

    send(OP_SUB, 8'd9, 8'd4, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.alu_sub) begin
        seen = 1'b1;
        break;
      end
    end
    chk("sub_strobe_seen", {31'd0, seen}, 32'd1);
    #1 res = 1'b0;
    #1;
    chk("async_rst_strobes", {20'd0, stb_vec, bus.alu0w, bus.alu1w}, 32'd0);
    chk("async_rst_ready",   {30'd0, bus.cmd_ready, bus.rsp_valid}, 32'd0);
    release_and_init("rerun");

    send(OP_ADD, 8'd10, 8'd20, 8'd30, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b1); wait_done();

    chk("onehot_violations", onehot_viol, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
